// File: rtl/lr35902_mtim.sv
// lr35902_mtim: multi-channel timer sharing one free-running 16-bit divider.
// Each channel counts falling edges of an enable-gated, selectable divider tap.
module lr35902_mtim #(
    parameter int CHANNELS = 2,
    parameter int ADR_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [7:0]       dout,
    input  logic [7:0]       din,
    input  logic [ADR_W-1:0] adr,
    input  logic             read,
    input  logic             write,
    output logic             irq
);
    // Tap select 0..7 -> divider bit index, one nibble per entry, entry 0 lowest
    localparam logic [31:0] TAP_MAP = {4'd15, 4'd1, 4'd13, 4'd11, 4'd7, 4'd5, 4'd3, 4'd9};

    logic [15:0]         div_q, div_d;
    logic [7:0]          cnt_q [CHANNELS];
    logic [7:0]          cnt_d [CHANNELS];
    logic [7:0]          rld_q [CHANNELS];
    logic [7:0]          rld_d [CHANNELS];
    logic [4:0]          ctl_q [CHANNELS];
    logic [4:0]          ctl_d [CHANNELS];
    logic [CHANNELS-1:0] if_q, if_d, ie_q, ie_d, tap_q, tap_d, inc, ovf;
    logic                rd_q, wr_q, irq_q, irq_d;
    logic [7:0]          dout_q, dout_d, rdat;
    logic                rd_edge, wr_edge;

    assign dout = dout_q;
    assign irq  = irq_q;

    always_comb begin
        rd_edge = read & ~rd_q;
        wr_edge = wr_q & ~write;
        div_d   = (wr_edge && adr == ADR_W'(0)) ? 16'h0000 : div_q + 16'd1;
        if_d    = (wr_edge && adr == ADR_W'(1)) ? if_q & ~din[CHANNELS-1:0] : if_q;
        ie_d    = (wr_edge && adr == ADR_W'(2)) ? din[CHANNELS-1:0] : ie_q;
        irq_d   = |(if_q & ie_q);
        tap_d   = '0;
        inc     = '0;
        ovf     = '0;
        rdat    = 8'hFF;
        if (adr == ADR_W'(0)) rdat = div_q[15:8];
        if (adr == ADR_W'(1)) rdat = {{(8-CHANNELS){1'b1}}, if_q};
        if (adr == ADR_W'(2)) rdat = {{(8-CHANNELS){1'b1}}, ie_q};
        for (int n = 0; n < CHANNELS; n++) begin
            tap_d[n] = div_q[TAP_MAP[{ctl_q[n][2:0], 2'b00} +: 4]] & ctl_q[n][3];
            inc[n]   = tap_q[n] & ~tap_d[n];
            ovf[n]   = inc[n] & (cnt_q[n] == 8'hFF);
            cnt_d[n] = ovf[n] ? rld_q[n] : cnt_q[n] + 8'(inc[n]);
            rld_d[n] = rld_q[n];
            ctl_d[n] = (ovf[n] & ctl_q[n][4]) ? {ctl_q[n][4], 1'b0, ctl_q[n][2:0]} : ctl_q[n];
            // Overflow set is applied after the write-1-to-clear so it takes priority
            if_d[n]  = if_d[n] | ovf[n];
            if (wr_edge && adr == ADR_W'(4*n+4)) cnt_d[n] = din;
            if (wr_edge && adr == ADR_W'(4*n+5)) rld_d[n] = din;
            if (wr_edge && adr == ADR_W'(4*n+6)) ctl_d[n] = din[4:0];
            if (adr == ADR_W'(4*n+4)) rdat = cnt_q[n];
            if (adr == ADR_W'(4*n+5)) rdat = rld_q[n];
            if (adr == ADR_W'(4*n+6)) rdat = {3'b111, ctl_q[n]};
        end
        dout_d = rd_edge ? rdat : dout_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            cnt_q  <= '{default: '0};
            rld_q  <= '{default: '0};
            ctl_q  <= '{default: '0};
            if_q   <= '0;
            ie_q   <= '0;
            tap_q  <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            dout_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            rld_q  <= rld_d;
            ctl_q  <= ctl_d;
            if_q   <= if_d;
            ie_q   <= ie_d;
            tap_q  <= tap_d;
            rd_q   <= read;
            wr_q   <= write;
            dout_q <= dout_d;
            irq_q  <= irq_d;
        end
    end
endmodule

// File: tb/tb_lr35902_mtim.sv
// tb_lr35902_mtim: scenario tasks for the multi-channel timer; register reads
// go through a scoreboard of expected values pushed when each read is issued.
module tb_lr35902_mtim;
    logic       clk = 1'b0, reset = 1'b1, read = 1'b0, write = 1'b0, irq;
    logic [7:0] din = 8'h00, dout;
    logic [3:0] adr = 4'h0;
    int         checks = 0, failures = 0, cyc = 0, d0 = 0;
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];
    string      nam_q [$];

    lr35902_mtim #(.CHANNELS(2), .ADR_W(4)) dut (
        .clk(clk), .reset(reset), .dout(dout), .din(din),
        .adr(adr), .read(read), .write(write), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic idle_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        read = 1'b0; write = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Write takes effect on the posedge where write is seen falling.
    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        adr = a; din = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        @(negedge clk);
    endtask

    task automatic sb_read(input logic [3:0] a, input logic [7:0] e, input string n);
        exp_q.push_back(e); nam_q.push_back(n);
        adr = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        obs_q.push_back(dout);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] e, o; string n;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %02h want 00", dout); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
        reset = 1'b0;
        sb_read(4'd0, 8'h00, "rst_div");
        sb_read(4'd1, 8'hFC, "rst_if");
        sb_read(4'd2, 8'hFC, "rst_ie");
        sb_read(4'd6, 8'hE0, "rst_ctrl0");
        sb_read(4'd9, 8'h00, "rst_reload1");
        sb_read(4'd3, 8'hFF, "reserved3");
        sb_read(4'd7, 8'hFF, "reserved7");
        sb_read(4'd12, 8'hFF, "unimpl12");
        sb_read(4'd14, 8'hFF, "unimpl14");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nam_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: dout=%02h expected=%02h", n, o, e); end
        end
    endtask

    task automatic test_periodic();
        logic [7:0] e, o; string n;
        do_reset();
        bus_write(4'd5, 8'hFE);
        bus_write(4'd4, 8'hFE);
        bus_write(4'd2, 8'h01);
        sb_read(4'd2, 8'hFD, "ie_written");
        bus_write(4'd0, 8'h00);
        d0 = cyc;
        bus_write(4'd6, 8'h09);
        idle_to(d0 + 20);
        sb_read(4'd4, 8'hFF, "cnt0_after16");
        sb_read(4'd1, 8'hFC, "if_before_ovf");
        idle_to(d0 + 33);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early: got %b want 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_after_if: got %b want 1", irq); end
        idle_to(d0 + 40);
        sb_read(4'd4, 8'hFE, "cnt0_after32");
        sb_read(4'd1, 8'hFD, "if_after_ovf");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nam_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: dout=%02h expected=%02h", n, o, e); end
        end
    endtask

    // Continues the channel 0 run started by test_periodic (overflows every 32 clk).
    task automatic test_races();
        logic [7:0] e, o; string n;
        idle_to(d0 + 63);
        bus_write(4'd1, 8'h01);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_race: got %b want 1", irq); end
        sb_read(4'd1, 8'hFD, "if_set_wins");
        bus_write(4'd1, 8'h01);
        sb_read(4'd1, 8'hFC, "if_w1c");
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_cleared: got %b want 0", irq); end
        idle_to(d0 + 95);
        bus_write(4'd4, 8'h33);
        sb_read(4'd4, 8'h33, "cnt_write_wins");
        sb_read(4'd1, 8'hFD, "if_set_on_cnt_write");
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_cnt_write: got %b want 1", irq); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nam_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: dout=%02h expected=%02h", n, o, e); end
        end
    endtask

    task automatic test_one_shot();
        logic [7:0] e, o; string n;
        do_reset();
        bus_write(4'd9, 8'h42);
        bus_write(4'd8, 8'hFF);
        bus_write(4'd0, 8'h00);
        d0 = cyc;
        bus_write(4'd10, 8'h19);
        idle_to(d0 + 20);
        sb_read(4'd8, 8'h42, "os_cnt_reload");
        sb_read(4'd1, 8'hFE, "os_if1");
        sb_read(4'd10, 8'hF1, "os_ctrl_disabled");
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL os_irq_masked: got %b want 0", irq); end
        idle_to(cyc + 1000);
        sb_read(4'd8, 8'h42, "os_no_more_counts");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nam_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: dout=%02h expected=%02h", n, o, e); end
        end
    endtask

    task automatic test_div_glitch();
        logic [7:0] e, o; string n;
        int ew;
        do_reset();
        bus_write(4'd4, 8'h10);
        bus_write(4'd0, 8'h00);
        d0 = cyc;
        bus_write(4'd6, 8'h08);
        idle_to(d0 + 600);
        sb_read(4'd0, 8'h02, "div_high_byte");
        sb_read(4'd4, 8'h10, "glitch_before");
        bus_write(4'd0, 8'h00);
        ew = cyc;
        idle_to(ew + 10);
        sb_read(4'd4, 8'h11, "glitch_one_inc");
        sb_read(4'd0, 8'h00, "div_cleared");
        idle_to(ew + 300);
        sb_read(4'd4, 8'h11, "glitch_stable");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nam_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: dout=%02h expected=%02h", n, o, e); end
        end
    endtask

    task automatic test_taps();
        logic [7:0] e, o; string n;
        do_reset();
        bus_write(4'd0, 8'h00);
        d0 = cyc;
        bus_write(4'd6, 8'h0E);
        bus_write(4'd10, 8'h0A);
        idle_to(d0 + 40);
        sb_read(4'd4, 8'h09, "tap6_bit1");
        sb_read(4'd8, 8'h00, "tap2_idle");
        idle_to(d0 + 140);
        sb_read(4'd8, 8'h02, "tap2_bit5");
        idle_to(d0 + 168);
        bus_write(4'd10, 8'h00);
        idle_to(d0 + 178);
        sb_read(4'd8, 8'h03, "disable_edge");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nam_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: dout=%02h expected=%02h", n, o, e); end
        end
    endtask

    task automatic test_read_edge();
        logic [7:0] e, o; string n;
        do_reset();
        bus_write(4'd2, 8'h01);
        sb_read(4'd2, 8'hFD, "ie_pre");
        bus_write(4'd0, 8'h00);
        exp_q.push_back(8'h00); nam_q.push_back("div_held_first");
        adr = 4'd0; read = 1'b1;
        @(negedge clk);
        obs_q.push_back(dout);
        repeat (9) @(negedge clk);
        adr = 4'd2;
        repeat (3) @(negedge clk);
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL read_level: dout=%02h expected=00", dout); end
        read = 1'b0;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nam_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: dout=%02h expected=%02h", n, o, e); end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e, o; string n;
        do_reset();
        bus_write(4'd2, 8'h01);
        bus_write(4'd5, 8'h80);
        bus_write(4'd4, 8'hFF);
        bus_write(4'd6, 8'h0E);
        idle_to(cyc + 10);
        sb_read(4'd2, 8'hFD, "pre_reset_ie");
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
        adr = 4'd4; din = 8'h77; write = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL async_dout: got %02h want 00", dout); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL async_irq: got %b want 0", irq); end
        checks++; if (dut.div_q !== 16'h0000) begin failures++; $display("FAIL async_div: got %04h want 0000", dut.div_q); end
        checks++; if (dut.cnt_q[0] !== 8'h00) begin failures++; $display("FAIL async_cnt0: got %02h want 00", dut.cnt_q[0]); end
        write = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (dut.div_q !== 16'h0001) begin failures++; $display("FAIL div_first_inc: got %04h want 0001", dut.div_q); end
        sb_read(4'd4, 8'h00, "write_aborted");
        sb_read(4'd2, 8'hFC, "ie_after_reset");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n = nam_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL %s: dout=%02h expected=%02h", n, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_races();
        test_one_shot();
        test_div_glitch();
        test_taps();
        test_read_edge();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
